wbgpio_edge: RTL and testbench

- Parametrised successor to the single-address GPIO controller.
- Up to 16 inputs and 16 outputs with set/clear-mask output writes.
- Adds per-pin rising/falling edge interrupt enables, a sticky write-1-to-clear status register, a parametrised synchroniser depth and a post-reset settling guard.
- Sits on the 32-bit pipelined wishbone bus as a 4-word slave (8 with the optional feature); drives one level interrupt to the PIC.

---
 rtl/wbgpio_edge_if.sv | 21 ++
 rtl/wbgpio_edge.sv | 126 ++++++++++++
 tb/tb_wbgpio_edge.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wbgpio_edge_if.sv
// Pipelined wishbone slave port of the edge-interrupt GPIO block (32-bit data, 3-bit word address).
interface wbgpio_edge_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [2:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_stall, o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_stall, o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/wbgpio_edge.sv
// GPIO with set/clear-mask outputs, per-pin rise/fall interrupt enables and W1C status.
// Optional TOGGLE register at word 4 when WBGPIO_TOGGLE_EN is defined.
module wbgpio_edge #(
  parameter int unsigned NIN     = 16,
  parameter int unsigned NOUT    = 16,
  parameter logic [15:0] DEFAULT = 16'h0000,
  parameter int unsigned NSYNC   = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  wbgpio_edge_if.slave    wb,
  input  logic [NIN-1:0]  i_gpio,
  output logic [NOUT-1:0] o_gpio,
  output logic            o_int
);

  localparam logic [2:0] SettleMax = 3'(NSYNC + 1);

  logic [NSYNC-1:0][NIN-1:0] sync_q, sync_d;
  logic [NIN-1:0]  prev_q, prev_d;
  logic [2:0]      settle_q, settle_d;
  logic [NIN-1:0]  rise_en_q, rise_en_d;
  logic [NIN-1:0]  fall_en_q, fall_en_d;
  logic [NIN-1:0]  status_q, status_d;
  logic [NOUT-1:0] gpio_q, gpio_d;
  logic            int_q, int_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [NIN-1:0]  synced;
  logic            settled;
  logic [NIN-1:0]  evt;
  logic [NIN-1:0]  w1c;
  logic            wr;
  logic [NOUT-1:0] set_mask;
  logic [NOUT-1:0] set_val;
  logic            unused_cyc;

  // Every strobe is a request; cyc is implied by stb.
  assign unused_cyc = wb.i_wb_cyc;

  assign synced   = sync_q[NSYNC-1];
  assign settled  = (settle_q == SettleMax);
  assign wr       = wb.i_wb_stb && wb.i_wb_we;
  assign set_mask = wb.i_wb_data[NOUT+15:16];
  assign set_val  = wb.i_wb_data[NOUT-1:0];

  always_comb begin
    sync_d   = {sync_q[NSYNC-2:0], i_gpio};
    prev_d   = synced;
    settle_d = settled ? settle_q : settle_q + 3'd1;
    // Edges are ignored until the synchroniser and prev sample hold real pin values.
    evt      = settled ? ((synced & ~prev_q & rise_en_q) | (~synced & prev_q & fall_en_q))
                       : '0;
    int_d    = |status_q;
    ack_d    = !i_reset && wb.i_wb_stb;

    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    gpio_d    = gpio_q;
    w1c       = '0;

    if (wr) begin
      case (wb.i_wb_addr)
        3'd0: gpio_d = (gpio_q & ~set_mask) | (set_val & set_mask);
        3'd1: rise_en_d = wb.i_wb_data[NIN-1:0];
        3'd2: fall_en_d = wb.i_wb_data[NIN-1:0];
        3'd3: w1c = wb.i_wb_data[NIN-1:0];
`ifdef WBGPIO_TOGGLE_EN
        3'd4: gpio_d = gpio_q ^ set_val;
`endif
        default: ;
      endcase
    end

    // A new event beats a simultaneous clear of the same bit.
    status_d = (status_q & ~w1c) | evt;

    rdata_d = 32'h0;
    if (wb.i_wb_stb) begin
      case (wb.i_wb_addr)
        3'd0: rdata_d = (32'(synced) << 16) | 32'(gpio_q);
        3'd1: rdata_d = 32'(rise_en_q);
        3'd2: rdata_d = 32'(fall_en_q);
        3'd3: rdata_d = 32'(status_q);
`ifdef WBGPIO_TOGGLE_EN
        3'd4: rdata_d = 32'(gpio_q);
`endif
        default: rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      settle_q  <= 3'd0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      gpio_q    <= DEFAULT[NOUT-1:0];
      int_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      settle_q  <= settle_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      gpio_q    <= gpio_d;
      int_q     <= int_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_data  = rdata_q;
  assign o_gpio        = gpio_q;
  assign o_int         = int_q;

endmodule

// File: tb/tb_wbgpio_edge.sv
// Directed scoreboard bench for wbgpio_edge (NSYNC=2, DEFAULT=0); follows WBGPIO_TOGGLE_EN.
module tb_wbgpio_edge;
  logic        clk;
  logic        rst;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  wbgpio_edge_if bus ();

  wbgpio_edge #(
    .NIN     (16),
    .NOUT    (16),
    .DEFAULT (16'h0000),
    .NSYNC   (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .wb      (bus),
    .i_gpio  (gpio_in),
    .o_gpio  (gpio_out),
    .o_int   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    check({tag, "_ack"}, 32'(bus.o_wb_ack), 32'h1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, bus.o_wb_data, e);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    check("ack_idle", 32'(bus.o_wb_ack), 32'h0);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
    bus.i_wb_addr = a; bus.i_wb_data = d;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    check("wr_ack", 32'(bus.o_wb_ack), 32'h1);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] a, input logic [31:0] expv);
    @(negedge clk);
    check("ack_idle", 32'(bus.o_wb_ack), 32'h0);
    exp_q.push_back(expv);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = a;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    pop_check(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] b2b [4];
    n_cmp = 0;
    n_err = 0;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = 3'd0; bus.i_wb_data = 32'h0;
    gpio_in = 16'hFFFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_int", 32'(irq), 32'h0);
    check("rst_ack", 32'(bus.o_wb_ack), 32'h0);
    check("rst_rdata", bus.o_wb_data, 32'h0);
    rst = 1'b0;

    // Pins high through reset must not raise a rise event.
    wb_write(3'd1, 32'h0000_FFFF);
    idle(6);
    check("settle_int", 32'(irq), 32'h0);
    wb_read("settle_status", 3'd3, 32'h0);
    wb_read("data_pins", 3'd0, 32'hFFFF_0000);

    wb_write(3'd0, 32'h0003_0001);
    check("gpio_set", 32'(gpio_out), 32'h0001);
    wb_write(3'd0, 32'h0002_0000);
    check("gpio_keep", 32'(gpio_out), 32'h0001);
    wb_write(3'd0, 32'h0001_0000);
    check("gpio_clr", 32'(gpio_out), 32'h0000);

    gpio_in = 16'h0000;
    idle(5);
    wb_write(3'd1, 32'h0000_0004);
    wb_read("status_quiet", 3'd3, 32'h0);

    // Rise on pin 2: STATUS sets at k+2, o_int at k+3; read sampled at k+2 sees pre-edge value.
    gpio_in = 16'h0004;
    @(negedge clk);
    check("rise_int_k", 32'(irq), 32'h0);
    @(negedge clk);
    exp_q.push_back(32'h0);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0; bus.i_wb_addr = 3'd3;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    pop_check("status_pre_edge");
    check("rise_int_k2", 32'(irq), 32'h0);
    @(negedge clk);
    check("rise_int_k3", 32'(irq), 32'h1);
    wb_read("status_rise", 3'd3, 32'h0000_0004);

    gpio_in = 16'h0000;
    idle(5);
    wb_read("status_nofall", 3'd3, 32'h0000_0004);
    wb_write(3'd1, 32'h0);
    wb_read("status_sticky", 3'd3, 32'h0000_0004);
    wb_write(3'd3, 32'h0000_0004);
    @(negedge clk);
    check("int_cleared", 32'(irq), 32'h0);
    wb_read("status_w1c", 3'd3, 32'h0);

    wb_write(3'd1, 32'h0000_0004);
    wb_write(3'd2, 32'h0000_0001);
    gpio_in = 16'h0001;
    idle(5);
    gpio_in = 16'h0005;
    idle(5);
    wb_read("status_b2", 3'd3, 32'h0000_0004);

    // Fall on pin 0 collides with W1C of bits 0 and 2: bit 0 survives, bit 2 clears.
    gpio_in = 16'h0004;
    @(negedge clk);
    @(negedge clk);
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 3'd3; bus.i_wb_data = 32'h0000_0005;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    check("w1c_race_ack", 32'(bus.o_wb_ack), 32'h1);
    check("w1c_race_int", 32'(irq), 32'h1);
    @(negedge clk);
    check("w1c_race_int2", 32'(irq), 32'h1);
    wb_read("status_race", 3'd3, 32'h0000_0001);
    wb_write(3'd3, 32'h0000_0001);
    check("int_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("int_drop", 32'(irq), 32'h0);

    b2b[0] = 32'h0004_0000;
    b2b[1] = 32'h0000_0004;
    b2b[2] = 32'h0000_0001;
    b2b[3] = 32'h0000_0000;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) pop_check("b2b");
      check("stall", 32'(bus.o_wb_stall), 32'h0);
      if (i < 4) begin
        exp_q.push_back(b2b[i]);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 3'(i);
      end else begin
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
      end
    end

    wb_write(3'd0, 32'h00FF_00F0);
    check("gpio_f0", 32'(gpio_out), 32'h00F0);
    wb_write(3'd4, 32'h0000_0FF0);
`ifdef WBGPIO_TOGGLE_EN
    check("toggle_gpio", 32'(gpio_out), 32'h0F00);
    wb_read("toggle_rd", 3'd4, 32'h0000_0F00);
`else
    check("toggle_gpio", 32'(gpio_out), 32'h00F0);
    wb_read("toggle_rd", 3'd4, 32'h0);
`endif
    wb_write(3'd7, 32'hFFFF_FFFF);
    wb_read("addr5_rd", 3'd5, 32'h0);
    wb_read("addr7_rd", 3'd7, 32'h0);

    // Reset landing on a strobe suppresses its ack and discards the write.
    @(negedge clk);
    rst = 1'b1;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
    bus.i_wb_addr = 3'd0; bus.i_wb_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    check("midrst_ack", 32'(bus.o_wb_ack), 32'h0);
    check("midrst_gpio", 32'(gpio_out), 32'h0);
    rst = 1'b0;
    wb_read("midrst_rise", 3'd1, 32'h0);
    wb_read("midrst_fall", 3'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
